// File: rtl/cbu_pkg.sv
// cbu_pkg: condition codes, FSM state type and CCR bit positions shared by the branch unit
package cbu_pkg;
  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_NE     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_LT     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_LE     = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;
  localparam int CCR_Z = 0;
  localparam int CCR_G = 1;
  localparam int CCR_L = 2;
  localparam int CCR_C = 3;
  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, EVAL} state_t;
  function automatic logic needs_flags(input logic [2:0] cond);
    return cond != COND_ALWAYS && cond != COND_NEVER;
  endfunction
endpackage

// File: rtl/cond_branch_unit_if.sv
// cond_branch_unit_if: branch request handshake (valid/ready, cond, target); master drives requests, slave accepts
interface cond_branch_unit_if #(parameter int PC_W = 8);
  logic br_valid;
  logic br_ready;
  logic [2:0] br_cond;
  logic [PC_W-1:0] br_target;
  modport master(output br_valid, br_cond, br_target, input br_ready);
  modport slave(input br_valid, br_cond, br_target, output br_ready);
endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational branch condition check; cond + raw z/g/l flags (z dominates g, g dominates l) -> result
module cond_eval
  import cbu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       g,
  input  logic       l,
  output logic       result
);
  logic g_eff, l_eff;
  always_comb begin
    g_eff = g & ~z;
    l_eff = l & ~z & ~g;
    result = 1'b0;
    case (cond)
      COND_ALWAYS: result = 1'b1;
      COND_EQ:     result = z;
      COND_NE:     result = ~z;
      COND_GT:     result = g_eff;
      COND_LT:     result = l_eff;
      COND_GE:     result = g_eff | z;
      COND_LE:     result = l_eff | z;
      default:     result = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: CCR + branch resolver; clk/rst, flag_valid+zf/cf/gf/lf in, step in, br handshake slave, pc/taken/done/ccr out
module cond_branch_unit
  import cbu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_valid,
  input  logic                 zf,
  input  logic                 cf,
  input  logic                 gf,
  input  logic                 lf,
  input  logic                 step,
  cond_branch_unit_if.slave    br,
  output logic [PC_W-1:0]      pc,
  output logic                 taken,
  output logic                 done,
  output logic [3:0]           ccr
);
  state_t state, state_nxt;
  logic fresh, fresh_nxt, accept, result, done_nxt, taken_nxt;
  logic [3:0] ccr_nxt;
  logic [2:0] cond_q, cond_nxt;
  logic [PC_W-1:0] target_q, target_nxt, pc_nxt;
  cond_eval u_eval (
    .cond  (cond_nxt),
    .z     (ccr_nxt[CCR_Z]),
    .g     (ccr_nxt[CCR_G]),
    .l     (ccr_nxt[CCR_L]),
    .result(result)
  );
  assign br.br_ready = (state == IDLE) & ~rst;
  assign accept = br.br_ready & br.br_valid;
  always_comb begin
    ccr_nxt = ccr;
    if (flag_valid) begin
      ccr_nxt[CCR_Z] = zf;
      ccr_nxt[CCR_G] = gf;
      ccr_nxt[CCR_L] = lf;
      ccr_nxt[CCR_C] = cf;
    end
    cond_nxt = accept ? br.br_cond : cond_q;
    target_nxt = accept ? br.br_target : target_q;
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = (!needs_flags(br.br_cond) || fresh || flag_valid) ? EVAL : WAIT_FLAGS;
      WAIT_FLAGS: if (flag_valid) state_nxt = EVAL;
      default:    state_nxt = IDLE;
    endcase
    done_nxt = state_nxt == EVAL;
    taken_nxt = done_nxt & result;
    fresh_nxt = flag_valid | (fresh & ~(state == EVAL && needs_flags(cond_q)));
    pc_nxt = (state == EVAL) ? (taken ? target_q : pc + 1'b1)
           : (state == IDLE && !br.br_valid && step) ? pc + 1'b1 : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ccr <= '0;
      fresh <= 1'b0;
      cond_q <= '0;
      target_q <= '0;
      pc <= '0;
      done <= 1'b0;
      taken <= 1'b0;
    end else begin
      state <= state_nxt;
      ccr <= ccr_nxt;
      fresh <= fresh_nxt;
      cond_q <= cond_nxt;
      target_q <= target_nxt;
      pc <= pc_nxt;
      done <= done_nxt;
      taken <= taken_nxt;
    end
  end
endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: directed + randomized checks of cond_branch_unit against a relational reference model
module tb_cond_branch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_valid = 1'b0, zf = 1'b0, cf = 1'b0, gf = 1'b0, lf = 1'b0, step = 1'b0;
  logic [7:0] pc;
  logic taken, done;
  logic [3:0] ccr;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_pc = 8'd0;
  logic [3:0] m_ccr = 4'd0;
  logic m_fresh = 1'b0;
  cond_branch_unit_if #(.PC_W(8)) br();
  cond_branch_unit #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .flag_valid(flag_valid), .zf(zf), .cf(cf), .gf(gf), .lf(lf),
    .step(step), .br(br), .pc(pc), .taken(taken), .done(done), .ccr(ccr)
  );
  always #5 clk = ~clk;
  function automatic logic model_take(input logic [2:0] c, input logic z, input logic g, input logic l);
    int rel;
    rel = z ? 0 : g ? 1 : l ? 2 : 3;
    case (c)
      3'd0: return 1'b1;
      3'd1: return rel == 0;
      3'd2: return rel != 0;
      3'd3: return rel == 1;
      3'd4: return rel == 2;
      3'd5: return rel == 0 || rel == 1;
      3'd6: return rel == 0 || rel == 2;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic set_flags(input logic z, input logic g, input logic l, input logic c);
    flag_valid = 1'b1; zf = z; gf = g; lf = l; cf = c;
    m_ccr = {c, l, g, z};
    m_fresh = 1'b1;
  endtask
  task automatic pulse_flags(input logic z, input logic g, input logic l, input logic c);
    set_flags(z, g, l, c);
    tick;
    flag_valid = 1'b0;
    chk("ccr_latch", ccr, m_ccr);
    chk("ccr_pc", pc, m_pc);
  endtask
  task automatic do_step;
    step = 1'b1;
    tick;
    step = 1'b0;
    m_pc = m_pc + 8'd1;
    chk("step_pc", pc, m_pc);
  endtask
  task automatic do_branch(input logic [2:0] c, input logic [7:0] t, input logic early,
                           input logic z, input logic g, input logic l, input logic fc,
                           input int stall, input logic st);
    logic need, exp;
    need = c != 3'd0 && c != 3'd7;
    chk("ready_idle", br.br_ready, 1);
    br.br_valid = 1'b1; br.br_cond = c; br.br_target = t; step = st;
    if (early) set_flags(z, g, l, fc);
    tick;
    br.br_valid = 1'b0; step = 1'b0; flag_valid = 1'b0;
    if (need && !m_fresh) begin
      for (int i = 0; i < stall; i++) begin
        step = 1'($urandom_range(0, 1));
        chk("stall_ready", br.br_ready, 0);
        chk("stall_done", done, 0);
        chk("stall_pc", pc, m_pc);
        tick;
      end
      step = 1'b0;
      chk("wait_ready", br.br_ready, 0);
      chk("wait_done", done, 0);
      set_flags(z, g, l, fc);
      tick;
      flag_valid = 1'b0;
    end
    exp = model_take(c, m_ccr[0], m_ccr[1], m_ccr[2]);
    chk("done", done, 1);
    chk("taken", taken, exp);
    chk("eval_ready", br.br_ready, 0);
    chk("eval_ccr", ccr, m_ccr);
    m_pc = exp ? t : m_pc + 8'd1;
    if (need) m_fresh = 1'b0;
    tick;
    chk("done_clear", done, 0);
    chk("taken_clear", taken, 0);
    chk("pc", pc, m_pc);
    chk("ready_back", br.br_ready, 1);
  endtask
  initial begin
    br.br_valid = 1'b1; br.br_cond = 3'd1; br.br_target = 8'h40;
    tick;
    tick;
    chk("rst_pc", pc, 0);
    chk("rst_ccr", ccr, 0);
    chk("rst_ready", br.br_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_taken", taken, 0);
    rst = 1'b0; br.br_valid = 1'b0;
    tick;
    chk("rel_ready", br.br_ready, 1);
    chk("rel_done", done, 0);
    chk("rel_pc", pc, 0);
    pulse_flags(1, 0, 0, 0);
    do_branch(3'd1, 8'h40, 0, 0, 0, 0, 0, 0, 0);
    do_branch(3'd0, 8'h10, 0, 0, 0, 0, 0, 0, 0);
    do_branch(3'd3, 8'h80, 0, 0, 1, 0, 0, 5, 0);
    do_branch(3'd0, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    pulse_flags(0, 0, 1, 0);
    do_branch(3'd3, 8'h33, 0, 0, 0, 0, 0, 0, 0);
    pulse_flags(1, 1, 1, 1);
    do_branch(3'd3, 8'h21, 0, 0, 0, 0, 0, 0, 0);
    pulse_flags(1, 1, 1, 1);
    do_branch(3'd5, 8'h22, 0, 0, 0, 0, 0, 0, 0);
    do_branch(3'd4, 8'h5A, 1, 0, 0, 1, 0, 0, 0);
    do_branch(3'd7, 8'h99, 0, 0, 0, 0, 0, 0, 1);
    do_step;
    br.br_valid = 1'b1; br.br_cond = 3'd4; br.br_target = 8'h55;
    tick;
    br.br_valid = 1'b0;
    chk("wf_ready", br.br_ready, 0);
    rst = 1'b1;
    tick;
    chk("wf_rst_pc", pc, 0);
    chk("wf_rst_done", done, 0);
    chk("wf_rst_ccr", ccr, 0);
    rst = 1'b0;
    m_pc = 8'd0; m_ccr = 4'd0; m_fresh = 1'b0;
    tick;
    chk("wf_rel_done", done, 0);
    chk("wf_rel_ready", br.br_ready, 1);
    pulse_flags(1, 0, 0, 0);
    br.br_valid = 1'b1; br.br_cond = 3'd1; br.br_target = 8'h77;
    tick;
    br.br_valid = 1'b0;
    chk("ev_done", done, 1);
    rst = 1'b1;
    tick;
    chk("ev_rst_pc", pc, 0);
    chk("ev_rst_done", done, 0);
    rst = 1'b0;
    m_pc = 8'd0; m_ccr = 4'd0; m_fresh = 1'b0;
    tick;
    chk("ev_rel_pc", pc, 0);
    do_branch(3'd6, 8'h12, 0, 0, 0, 0, 1, 2, 0);
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: pulse_flags(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        1: do_step;
        default: do_branch(3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
